e203_exu_fpu_fcmp_sched: RTL and testbench
==========================================

// Module: e203_exu_fpu_fcmp_sched
// PURPOSE
//  Round-robin scheduler that shares one single-precision compare datapath (FEQ/FLT/FLE, optionally FMIN/FMAX)
//  between NREQ requesters in the FPU issue path. Owns arbitration, operation sequencing, the IEEE-754
//  NaN/signed-zero policy, NV flag generation and a registered response stage with valid/ready backpressure.
//  It sits between the FPU dispatch/replay queues and the FPU writeback arbiter.
// PARAMETERS
//  NREQ   2  number of requesters (2..4)
//  TAG_W  4  opaque tag width, returned unchanged with the result
//  SRC_W  1  width of rsp_src; must equal clog2(NREQ), 1 when NREQ=2
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst          in   1          synchronous reset, active-high
//  req_valid    in   NREQ       per-requester request valid
//  req_ready    out  NREQ       per-requester accept; at most one bit set per cycle
//  req_op       in   3*NREQ     op: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX, 5-7 reserved
//  req_rs1      in   32*NREQ    operand a (binary32)
//  req_rs2      in   32*NREQ    operand b (binary32)
//  req_tag      in   TAG_W*NREQ opaque tag
//  rsp_valid    out  1          result valid
//  rsp_ready    in   1          writeback accepts result
//  rsp_wdat     out  32         result: 0/1 for compares, binary32 for min/max
//  rsp_fflags   out  5          {NV,DZ,OF,UF,NX}; only NV is ever set
//  rsp_tag      out  TAG_W      tag of the answered request
//  rsp_src      out  SRC_W      index of the requester that issued it
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, rr_ptr=0. A rst pulse in RESP drops the held result without a response.
//  - FSM: IDLE -> RESP on accept; RESP -> IDLE on rsp_ready & no new accept; RESP -> RESP on rsp_ready & accept.
//  - Accept condition: can_acc = (state==IDLE) | rsp_ready. req_ready[i] = can_acc & grant[i].
//  - Grant: round-robin starting at rr_ptr among asserted req_valid bits; grant is combinational from valid.
//    On accept of requester g, rr_ptr <= (g+1) mod NREQ; rr_ptr holds when no accept occurs.
//  - Latency: exactly 1 cycle from accept to rsp_valid; full throughput (1 op/cycle) while rsp_ready=1.
//  - Result registers (wdat, fflags, tag, src) load only on accept; they stay stable while rsp_valid & ~rsp_ready.
//  - NaN: qNaN = exp 0xFF, man != 0, man[22]=1; sNaN = exp 0xFF, man != 0, man[22]=0.
//  - FEQ: any NaN -> 0; NV only if an operand is sNaN. +0 == -0 -> 1. Otherwise bitwise equality.
//  - FLT/FLE: any NaN -> 0, NV=1. -0 vs +0 equal (FLT 0, FLE 1). Sign/magnitude ordering; with both negative,
//    the larger magnitude is the lesser value.
//  - FMIN/FMAX: both NaN -> 32'h7FC00000; one NaN -> the other operand; NV if an operand is sNaN.
//    -0 is ordered below +0 (FMIN(+0,-0) = -0, FMAX = +0).
//  - Reserved ops (5-7): accepted, rsp_wdat=0, rsp_fflags=0.
//  - Simultaneous rsp_ready and new request in RESP: new result replaces the old in the same edge, no bubble.
//  - Requester dropping req_valid before acceptance is legal and has no effect on state.
// CONFIGURATION
//  E203_FPU_FCMP_MINMAX_EN defined: FMIN/FMAX implemented as above.
//  Not defined: ops 3/4 behave as reserved (wdat=0, fflags=0), and the min/max mux and canonical-NaN logic are
//  removed; FEQ/FLT/FLE, arbitration and timing are unchanged.
// STRUCTURE
//  Shared FPU package/header: op encodings (FCMP_OP_FEQ..FMAX), FP32_CANON_NAN=32'h7FC00000, FFLAG_NV bit index,
//    binary32 field-extract macros.
//  One sub-module: e203_exu_fpu_fcmp_core (combinational: a, b, op -> wdat, nv), instantiated once and fed by
//    the grant mux. Arbiter, FSM and response registers live in the top module.
// TESTING
//  1 rst=1 for 2 cycles with req_valid=all ones -> req_ready=0, rsp_valid=0, rsp_wdat=0, rr_ptr=0.
//  2 req0 FLT a=3F800000 b=40000000, tag=5 -> next cycle rsp_valid=1, wdat=1, fflags=0, tag=5, src=0.
//  3 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one response per cycle.
//  4 rsp_ready=0 for 3 cycles after a response -> rsp_* stable and req_ready=0; rsp_ready=1 with req1 pending
//    -> new accept that same cycle.
//  5 FEQ a=7FA00000 (sNaN) b=0 -> wdat=0, NV=1; FLE a=80000000 b=00000000 -> wdat=1, NV=0;
//    FLT a=7FC00000 b=0 -> wdat=0, NV=1.
//  6 With MINMAX_EN: FMIN 00000000/80000000 -> 80000000; FMAX 7FC00000/7FC00000 -> 7FC00000;
//    FMAX 7FA00000/3F800000 -> 3F800000 with NV=1. Without the macro, op 3 -> wdat 0, fflags 0.

Source files
------------

// File: rtl/e203_exu_fpu_fcmp_pkg.sv
// Shared FPU compare definitions: op encodings, canonical NaN, fflags bit index,
// scheduler states and binary32 field helpers.
package e203_exu_fpu_fcmp_pkg;

    typedef enum logic [2:0] {
        FCMP_OP_FEQ  = 3'd0,
        FCMP_OP_FLT  = 3'd1,
        FCMP_OP_FLE  = 3'd2,
        FCMP_OP_FMIN = 3'd3,
        FCMP_OP_FMAX = 3'd4
    } fcmp_op_e;

    typedef enum logic {
        FCMP_IDLE = 1'b0,
        FCMP_RESP = 1'b1
    } fcmp_state_e;

    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
    localparam int          FFLAG_NV       = 4;

    function automatic logic [7:0] fp32_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp32_man(input logic [31:0] x);
        return x[22:0];
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (fp32_exp(x) == 8'hFF) && (fp32_man(x) != 23'd0);
    endfunction

    // Signalling NaNs have the quiet bit (mantissa MSB) clear.
    function automatic logic fp32_is_snan(input logic [31:0] x);
        return fp32_is_nan(x) && !x[22];
    endfunction

endpackage

// File: rtl/e203_exu_fpu_fcmp_core.sv
// Combinational binary32 compare datapath (FEQ/FLT/FLE, FMIN/FMAX when
// E203_FPU_FCMP_MINMAX_EN is defined). Produces the result word and the NV flag.
module e203_exu_fpu_fcmp_core
    import e203_exu_fpu_fcmp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] wdat,
    output logic        nv
);

    logic a_nan, b_nan, a_snan, b_snan, any_nan, any_snan;
    logic both_zero, eq, a_lt_b, lt;
    logic [30:0] a_mag, b_mag;

    assign a_nan    = fp32_is_nan(a);
    assign b_nan    = fp32_is_nan(b);
    assign a_snan   = fp32_is_snan(a);
    assign b_snan   = fp32_is_snan(b);
    assign any_nan  = a_nan | b_nan;
    assign any_snan = a_snan | b_snan;

    assign a_mag     = a[30:0];
    assign b_mag     = b[30:0];
    assign both_zero = (a_mag == 31'd0) && (b_mag == 31'd0);
    assign eq        = both_zero || (a == b);

    // Total order on sign/magnitude with -0 below +0; negative values reverse magnitude order.
    assign a_lt_b = (a[31] != b[31]) ? a[31] :
                    (a[31] ? (a_mag > b_mag) : (a_mag < b_mag));
    assign lt     = a_lt_b && !both_zero;

    always_comb begin
        wdat = 32'd0;
        nv   = 1'b0;
        case (op)
            FCMP_OP_FEQ: begin
                wdat = {31'd0, eq && !any_nan};
                nv   = any_snan;
            end
            FCMP_OP_FLT: begin
                wdat = {31'd0, lt && !any_nan};
                nv   = any_nan;
            end
            FCMP_OP_FLE: begin
                wdat = {31'd0, (lt || eq) && !any_nan};
                nv   = any_nan;
            end
`ifdef E203_FPU_FCMP_MINMAX_EN
            FCMP_OP_FMIN, FCMP_OP_FMAX: begin
                if (a_nan && b_nan)
                    wdat = FP32_CANON_NAN;
                else if (a_nan)
                    wdat = b;
                else if (b_nan)
                    wdat = a;
                else if (op == FCMP_OP_FMIN)
                    wdat = a_lt_b ? a : b;
                else
                    wdat = a_lt_b ? b : a;
                nv = any_snan;
            end
`endif
            default: begin
                wdat = 32'd0;
                nv   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/e203_exu_fpu_fcmp_sched.sv
// Round-robin scheduler sharing one FP compare datapath among NREQ requesters,
// with a registered valid/ready response stage. FMIN/FMAX need E203_FPU_FCMP_MINMAX_EN.
module e203_exu_fpu_fcmp_sched
    import e203_exu_fpu_fcmp_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    parameter int SRC_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [32*NREQ-1:0]    req_rs1,
    input  logic [32*NREQ-1:0]    req_rs2,
    input  logic [TAG_W*NREQ-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_wdat,
    output logic [4:0]            rsp_fflags,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [SRC_W-1:0]      rsp_src
);

    fcmp_state_e      state;
    logic [SRC_W-1:0] rr_ptr, cand, gnt_idx, rr_nxt;
    logic [NREQ-1:0]  gnt;
    logic             any_vld, can_acc, accept;
    logic [31:0]      a_p0, b_p0, wdat_p0;
    logic [2:0]       op_p0;
    logic             nv_p0;
    logic [4:0]       fflags_p0;

    logic [31:0]      wdat_p1;
    logic [4:0]       fflags_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [SRC_W-1:0] src_p1;

    // Stage p0: round-robin grant from rr_ptr and operand mux into the shared datapath.
    always_comb begin
        any_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NREQ);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt[gnt_idx] = any_vld;
    end

    assign rr_nxt    = SRC_W'((int'(gnt_idx) + 1) % NREQ);
    assign can_acc   = !rst && ((state == FCMP_IDLE) || rsp_ready);
    assign accept    = can_acc && any_vld;
    assign req_ready = can_acc ? gnt : '0;

    assign a_p0  = req_rs1[gnt_idx*32 +: 32];
    assign b_p0  = req_rs2[gnt_idx*32 +: 32];
    assign op_p0 = req_op[gnt_idx*3 +: 3];

    e203_exu_fpu_fcmp_core u_core (
        .a    (a_p0),
        .b    (b_p0),
        .op   (op_p0),
        .wdat (wdat_p0),
        .nv   (nv_p0)
    );

    always_comb begin
        fflags_p0           = '0;
        fflags_p0[FFLAG_NV] = nv_p0;
    end

    // Stage p1: response registers; a new accept overwrites the held result in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FCMP_IDLE;
            rr_ptr    <= '0;
            wdat_p1   <= '0;
            fflags_p1 <= '0;
            tag_p1    <= '0;
            src_p1    <= '0;
        end else if (accept) begin
            state     <= FCMP_RESP;
            rr_ptr    <= rr_nxt;
            wdat_p1   <= wdat_p0;
            fflags_p1 <= fflags_p0;
            tag_p1    <= req_tag[gnt_idx*TAG_W +: TAG_W];
            src_p1    <= gnt_idx;
        end else if (rsp_ready) begin
            state     <= FCMP_IDLE;
        end
    end

    assign rsp_valid  = (state == FCMP_RESP);
    assign rsp_wdat   = wdat_p1;
    assign rsp_fflags = fflags_p1;
    assign rsp_tag    = tag_p1;
    assign rsp_src    = src_p1;

endmodule

// File: tb/tb_e203_exu_fpu_fcmp_sched.sv
// Directed plus randomized bench for e203_exu_fpu_fcmp_sched against a behavioural
// model (real-valued ordering, queue-free round robin). Honours E203_FPU_FCMP_MINMAX_EN.
module tb_e203_exu_fpu_fcmp_sched;

    localparam int NREQ  = 2;
    localparam int TAG_W = 4;
    localparam int SRC_W = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [32*NREQ-1:0]    req_rs1;
    logic [32*NREQ-1:0]    req_rs2;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_wdat;
    logic [4:0]            rsp_fflags;
    logic [TAG_W-1:0]      rsp_tag;
    logic [SRC_W-1:0]      rsp_src;

    e203_exu_fpu_fcmp_sched #(.NREQ(NREQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wdat   (rsp_wdat),
        .rsp_fflags (rsp_fflags),
        .rsp_tag    (rsp_tag),
        .rsp_src    (rsp_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state of the scheduler
    bit          m_vld;
    int          m_rr;
    logic [31:0] m_w;
    logic [4:0]  m_f;
    logic [3:0]  m_tag;
    int          m_src;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 0) m = (real'(x[22:0]) / 8388608.0) * (2.0 ** -126);
        else        m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -m : m;
    endfunction

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] w, output logic nv);
        bit  an, bn, as, bs;
        real ra, rb;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        as = an && !a[22];
        bs = bn && !b[22];
        ra = to_real(a);
        rb = to_real(b);
        w  = 32'd0;
        nv = 1'b0;
        case (op)
            3'd0: begin w = {31'd0, !an && !bn && (ra == rb)}; nv = as || bs; end
            3'd1: begin w = {31'd0, !an && !bn && (ra <  rb)}; nv = an || bn; end
            3'd2: begin w = {31'd0, !an && !bn && (ra <= rb)}; nv = an || bn; end
`ifdef E203_FPU_FCMP_MINMAX_EN
            3'd3, 3'd4: begin
                nv = as || bs;
                if (an && bn) w = 32'h7FC0_0000;
                else if (an)  w = b;
                else if (bn)  w = a;
                else if (ra == rb) begin
                    // zeros of either sign, or identical values
                    if (op == 3'd3) w = a[31] ? a : b;
                    else            w = a[31] ? b : a;
                end else if (op == 3'd3) w = (ra < rb) ? a : b;
                else                     w = (ra < rb) ? b : a;
            end
`endif
            default: ;
        endcase
    endfunction

    task automatic drive(input int i, input bit v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_valid[i]            = v;
        req_op[i*3 +: 3]        = op;
        req_rs1[i*32 +: 32]     = a;
        req_rs2[i*32 +: 32]     = b;
        req_tag[i*TAG_W +: TAG_W] = tag;
    endtask

    // One clock: check req_ready before the edge, advance model, check responses after.
    task automatic run_cycle(input string nm);
        int          g;
        bit          acc;
        logic [1:0]  er;
        logic [31:0] w;
        logic        nv;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        acc = !rst && (!m_vld || rsp_ready) && (g >= 0);
        er  = '0;
        if (acc) er[g] = 1'b1;
        chk({nm, "_ready"}, 32'(req_ready), 32'(er));
        w = 32'd0;
        nv = 1'b0;
        if (acc) ref_op(req_op[g*3 +: 3], req_rs1[g*32 +: 32], req_rs2[g*32 +: 32], w, nv);
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_rr = 0; m_w = 0; m_f = 0; m_tag = 0; m_src = 0;
        end else if (acc) begin
            m_vld = 1; m_rr = (g + 1) % NREQ; m_w = w; m_f = {nv, 4'b0};
            m_tag = req_tag[g*TAG_W +: TAG_W]; m_src = g;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        #1;
        chk({nm, "_valid"},  32'(rsp_valid),  32'(m_vld));
        chk({nm, "_wdat"},   rsp_wdat,        m_w);
        chk({nm, "_fflags"}, 32'(rsp_fflags), 32'(m_f));
        chk({nm, "_tag"},    32'(rsp_tag),    32'(m_tag));
        chk({nm, "_src"},    32'(rsp_src),    32'(m_src));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] tbl [12];
        tbl = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                32'h4000_0000, 32'hC000_0000, 32'h7FC0_0000, 32'h7FA0_0000,
                32'hFFC0_0001, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 11)];
        return $urandom();
    endfunction

    logic [31:0] held_w;

    initial begin
        m_vld = 0; m_rr = 0; m_w = 0; m_f = 0; m_tag = 0; m_src = 0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
        drive(0, 1, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd1);
        drive(1, 1, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd2);

        // Reset with all requesters valid
        @(posedge clk);
        run_cycle("reset");
        chk("reset_rsp_wdat", rsp_wdat, 32'd0);
        rst = 1'b0;
        drive(1, 0, 3'd0, 32'd0, 32'd0, 4'd0);

        // req0 FLT 1.0 < 2.0
        drive(0, 1, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd5);
        run_cycle("flt_basic");
        chk("flt_basic_wdat_const", rsp_wdat, 32'd1);
        chk("flt_basic_tag_const", 32'(rsp_tag), 32'd5);

        // Reset while a response is held drops it
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        run_cycle("rst_in_resp");
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Both requesters busy: grants alternate 0,1,0,1
        drive(0, 1, 3'd2, 32'h4000_0000, 32'h3F80_0000, 4'd3);
        drive(1, 1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd9);
        for (int i = 0; i < 4; i++) begin
            run_cycle("rr");
            chk("rr_src_seq", 32'(rsp_src), 32'(i % 2));
        end

        // Backpressure: response held stable, nothing accepted
        held_w = rsp_wdat;
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            run_cycle("hold");
            chk("hold_wdat_stable", rsp_wdat, held_w);
            chk("hold_ready_zero", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        run_cycle("release");
        chk("release_src", 32'(rsp_src), 32'd1);

        // NaN / signed-zero policy on the compares
        req_valid = '0;
        drive(0, 1, 3'd0, 32'h7FA0_0000, 32'h0000_0000, 4'd1);
        run_cycle("feq_snan");
        chk("feq_snan_nv", 32'(rsp_fflags), 32'h10);
        drive(0, 1, 3'd2, 32'h8000_0000, 32'h0000_0000, 4'd2);
        run_cycle("fle_zeros");
        chk("fle_zeros_w", rsp_wdat, 32'd1);
        drive(0, 1, 3'd1, 32'h7FC0_0000, 32'h0000_0000, 4'd3);
        run_cycle("flt_qnan");
        chk("flt_qnan_nv", 32'(rsp_fflags), 32'h10);

`ifdef E203_FPU_FCMP_MINMAX_EN
        drive(0, 1, 3'd3, 32'h0000_0000, 32'h8000_0000, 4'd4);
        run_cycle("fmin_zero");
        chk("fmin_zero_w", rsp_wdat, 32'h8000_0000);
        drive(0, 1, 3'd4, 32'h7FC0_0000, 32'h7FC0_0000, 4'd5);
        run_cycle("fmax_nan");
        chk("fmax_nan_w", rsp_wdat, 32'h7FC0_0000);
        drive(0, 1, 3'd4, 32'h7FA0_0000, 32'h3F80_0000, 4'd6);
        run_cycle("fmax_snan");
        chk("fmax_snan_w", rsp_wdat, 32'h3F80_0000);
        chk("fmax_snan_nv", 32'(rsp_fflags), 32'h10);
`else
        drive(0, 1, 3'd3, 32'h3F80_0000, 32'h4000_0000, 4'd4);
        run_cycle("op3_reserved");
        chk("op3_reserved_w", rsp_wdat, 32'd0);
        chk("op3_reserved_ff", 32'(rsp_fflags), 32'd0);
`endif
        drive(0, 1, 3'd6, 32'h7FA0_0000, 32'h3F80_0000, 4'd7);
        run_cycle("op6_reserved");
        chk("op6_reserved_ff", 32'(rsp_fflags), 32'd0);

        // Randomized traffic with backpressure and occasional reset
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                drive(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      pick_operand(), pick_operand(), 4'($urandom_range(0, 15)));
            run_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
